// File: rtl/reg_file_pkg.sv
// Shared types and constants for the reg_file register bank.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } reg_file_state_t;

    localparam int REG_FILE_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/reg_file_sweeper.sv
// Clear sequencer for reg_file: walks every entry once, issuing a zero write per cycle.
//   state | meaning
//   IDLE  | user port owns the write path; clear starts a sweep
//   SWEEP | one entry zeroed per edge, ptr advances; busy high
module reg_file_sweeper
    import reg_file_pkg::*;
#(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_sweep_we,
    output logic [ADDR_W-1:0] o_sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    reg_file_state_t   r_state;
    reg_file_state_t   w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (i_clear) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                // clear requests are ignored here so a running sweep never restarts
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == LAST_ADDR) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign o_busy       = (r_state == SWEEP);
    assign o_sweep_we   = (r_state == SWEEP) && !rst;
    assign o_sweep_addr = r_ptr;

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register bank, one write port, two combinational read ports, hardware clear.
// Optional write-through forwarding on the read ports when REG_FILE_BYPASS_EN is defined.
module reg_file
    import reg_file_pkg::*;
#(
    parameter  int WIDTH  = REG_FILE_DEFAULT_WIDTH,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    input  logic              clear,
    output logic              busy
);

    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_user_we;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_data;

    reg_file_sweeper #(
        .DEPTH (DEPTH)
    ) u_sweeper (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (clear),
        .o_busy       (busy),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr)
    );

    // clear beats load, and anything arriving while busy is dropped
    assign w_user_we = load && !clear && !busy && !rst;
    assign w_we      = w_sweep_we || w_user_we;
    assign w_addr    = w_sweep_we ? w_sweep_addr : addr_w;
    assign w_data    = w_sweep_we ? '0 : in;

    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            r_mem[w_addr] <= w_data;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    assign out_a = (w_user_we && (addr_a == addr_w)) ? in : r_mem[addr_a];
    assign out_b = (w_user_we && (addr_b == addr_w)) ? in : r_mem[addr_b];
`else
    assign out_a = r_mem[addr_a];
    assign out_b = r_mem[addr_b];
`endif

endmodule
